// File: rtl/key_debounce_pulse.sv
// Debounces the raw active-low pushbutton KEY[0] into a registered clean level,
// a one-cycle press pulse and a wrap-around count of accepted presses.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  output logic       KEY_CLEAN,
  output logic       KEY_PULSE,
  output logic [7:0] PRESS_CNT
);

  localparam int unsigned PCNT_W = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  logic                 rst_n;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 pressed;
  state_e               state_q;
  state_e               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 clean_q;
  logic                 clean_d;
  logic                 pulse_q;
  logic                 pulse_d;
  logic [PCNT_W-1:0]    press_cnt_q;
  logic [PCNT_W-1:0]    press_cnt_d;

  assign rst_n = KEY[1];

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= KEY[0];
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // State and qualification counter register.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: any bounce inside a WAIT state falls back to the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    clean_d     = 1'b0;
    pulse_d     = 1'b0;
    press_cnt_d = press_cnt_q;
    if ((state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT)) begin
      clean_d = 1'b1;
    end
    if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
      pulse_d     = 1'b1;
      press_cnt_d = press_cnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      clean_q     <= 1'b0;
      pulse_q     <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      clean_q     <= clean_d;
      pulse_q     <= pulse_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign KEY_CLEAN = clean_q;
  assign KEY_PULSE = pulse_q;
  assign PRESS_CNT = press_cnt_q;

endmodule
